// File: rtl/lz77_match_finder_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the LZ77 match finder.
package lz77_pkg;

    localparam int DEF_SYM_W    = 8;
    localparam int DEF_LA_DEPTH = 8;
    localparam int DEF_SB_DEPTH = 9;

    function automatic int ofs_width(input int sb_depth);
        return ($clog2(sb_depth) < 1) ? 1 : $clog2(sb_depth);
    endfunction

    localparam int DEF_LEN_W = $clog2(DEF_LA_DEPTH);
    localparam int DEF_OFS_W = ofs_width(DEF_SB_DEPTH);
    localparam int DEF_CNT_W = $clog2(DEF_SB_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lz77_match_finder_if.sv
// Request/result bundle between the LZ77 encoder control and the match finder.
interface lz77_match_finder_if
    import lz77_pkg::*;
#(
    parameter int SYM_W    = DEF_SYM_W,
    parameter int LA_DEPTH = DEF_LA_DEPTH,
    parameter int SB_DEPTH = DEF_SB_DEPTH
);
    localparam int LEN_W = $clog2(LA_DEPTH);
    localparam int OFS_W = ofs_width(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    logic                         start;
    logic [SB_DEPTH*SYM_W-1:0]    sb_buf;
    logic [CNT_W-1:0]             sb_valid;
    logic [LA_DEPTH*SYM_W-1:0]    la_buf;
    logic [LEN_W:0]               la_valid;
    logic                         busy;
    logic                         done;
    logic [LEN_W-1:0]             match_len;
    logic [OFS_W-1:0]             match_ofs;
    logic [SYM_W-1:0]             next_sym;

    modport master (
        output start, sb_buf, sb_valid, la_buf, la_valid,
        input  busy, done, match_len, match_ofs, next_sym
    );

    modport slave (
        input  start, sb_buf, sb_valid, la_buf, la_valid,
        output busy, done, match_len, match_ofs, next_sym
    );

endinterface

// File: rtl/lz77_match_finder_prefix_len_cmp.sv
// Combinational leading-equal-symbol count of two N-symbol strings, saturating at N.
module prefix_len_cmp #(
    parameter  int SYM_W = 8,
    parameter  int N     = 7,
    localparam int LW    = $clog2(N + 1)
) (
    input  logic [N*SYM_W-1:0] a_i,
    input  logic [N*SYM_W-1:0] b_i,
    output logic [LW-1:0]      len_o
);

    logic [N-1:0] mm_s;

    // Per-symbol mismatch flags
    always_comb begin
        mm_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            mm_s[i] = (a_i[i*SYM_W +: SYM_W] != b_i[i*SYM_W +: SYM_W]);
        end
    end

    // Priority encoder: lowest mismatching index wins, none means full length
    always_comb begin
        len_o = LW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            len_o = mm_s[i] ? LW'(i) : len_o;
        end
    end

endmodule

// File: rtl/lz77_match_finder.sv
// Sequential longest-match search: one candidate distance per cycle over the captured window.
module lz77_match_finder
    import lz77_pkg::*;
#(
    parameter int SYM_W    = DEF_SYM_W,
    parameter int LA_DEPTH = DEF_LA_DEPTH,
    parameter int SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    lz77_match_finder_if.slave   bus
);

    localparam int LEN_W = $clog2(LA_DEPTH);
    localparam int OFS_W = ofs_width(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);
    localparam int N     = LA_DEPTH - 1;
    localparam int CW    = N * SYM_W;
    localparam int SBW   = SB_DEPTH * SYM_W;
    localparam int LAW   = LA_DEPTH * SYM_W;

    state_e             state_q, state_d;
    logic [SBW-1:0]     sb_q, sb_d;
    logic [LAW-1:0]     la_q, la_d;
    logic [CNT_W-1:0]   sbv_q, sbv_d;
    logic [LEN_W-1:0]   cap_q, cap_d;
    logic [CNT_W-1:0]   d_q, d_d;
    logic [LEN_W-1:0]   best_len_q, best_len_d;
    logic [OFS_W-1:0]   best_ofs_q, best_ofs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   match_len_q, match_len_d;
    logic [OFS_W-1:0]   match_ofs_q, match_ofs_d;
    logic [SYM_W-1:0]   next_sym_q, next_sym_d;

    logic [CNT_W-1:0]   sbv_in_s;
    logic [LEN_W:0]     lav_in_s;
    logic [LEN_W-1:0]   cap_in_s;
    logic [SBW+CW-1:0]  s_vec_s;
    logic [CW-1:0]      cand_s;
    logic [LEN_W-1:0]   raw_len_s;
    logic [LEN_W-1:0]   clip_len_s;
    logic [LEN_W-1:0]   new_len_s;
    logic [OFS_W-1:0]   new_ofs_s;
    logic [SYM_W-1:0]   new_sym_s;

    assign sbv_in_s = (bus.sb_valid > CNT_W'(SB_DEPTH)) ? CNT_W'(SB_DEPTH) : bus.sb_valid;
    assign lav_in_s = ((bus.la_valid == (LEN_W+1)'(0)) || (bus.la_valid > (LEN_W+1)'(LA_DEPTH)))
                    ? (LEN_W+1)'(LA_DEPTH) : bus.la_valid;
    assign cap_in_s = LEN_W'(lav_in_s - (LEN_W+1)'(1));

    // The last look-ahead symbol can never be part of a candidate, so S stops one short
    assign s_vec_s   = {la_q[CW-1:0], sb_q};
    assign cand_s    = CW'(s_vec_s >> ((SB_DEPTH - int'(d_q)) * SYM_W));
    assign new_sym_s = SYM_W'(la_q >> (int'(new_len_s) * SYM_W));

    prefix_len_cmp #(
        .SYM_W (SYM_W),
        .N     (N)
    ) u_cmp (
        .a_i   (cand_s),
        .b_i   (la_q[CW-1:0]),
        .len_o (raw_len_s)
    );

    // Clip to the stream tail and fold the candidate into the running best (ties keep smaller d)
    always_comb begin
        clip_len_s = (raw_len_s > cap_q) ? cap_q : raw_len_s;
        if (clip_len_s > best_len_q) begin
            new_len_s = clip_len_s;
            new_ofs_s = OFS_W'(d_q - CNT_W'(1));
        end else begin
            new_len_s = best_len_q;
            new_ofs_s = best_ofs_q;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        sb_d        = sb_q;
        la_d        = la_q;
        sbv_d       = sbv_q;
        cap_d       = cap_q;
        d_d         = d_q;
        best_len_d  = best_len_q;
        best_ofs_d  = best_ofs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        match_len_d = match_len_q;
        match_ofs_d = match_ofs_q;
        next_sym_d  = next_sym_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    sb_d       = bus.sb_buf;
                    la_d       = bus.la_buf;
                    sbv_d      = sbv_in_s;
                    cap_d      = cap_in_s;
                    d_d        = CNT_W'(1);
                    best_len_d = LEN_W'(0);
                    best_ofs_d = OFS_W'(0);
                    if ((sbv_in_s == CNT_W'(0)) || (cap_in_s == LEN_W'(0))) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        match_len_d = LEN_W'(0);
                        match_ofs_d = OFS_W'(0);
                        next_sym_d  = bus.la_buf[SYM_W-1:0];
                    end else begin
                        state_d = SCAN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                best_len_d = new_len_s;
                best_ofs_d = new_ofs_s;
                if ((d_q == sbv_q) || (new_len_s == cap_q)) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    match_len_d = new_len_s;
                    match_ofs_d = new_ofs_s;
                    next_sym_d  = new_sym_s;
                end else begin
                    d_d = d_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sb_q        <= {SBW{1'b0}};
            la_q        <= {LAW{1'b0}};
            sbv_q       <= CNT_W'(0);
            cap_q       <= LEN_W'(0);
            d_q         <= CNT_W'(0);
            best_len_q  <= LEN_W'(0);
            best_ofs_q  <= OFS_W'(0);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_len_q <= LEN_W'(0);
            match_ofs_q <= OFS_W'(0);
            next_sym_q  <= SYM_W'(0);
        end else begin
            state_q     <= state_d;
            sb_q        <= sb_d;
            la_q        <= la_d;
            sbv_q       <= sbv_d;
            cap_q       <= cap_d;
            d_q         <= d_d;
            best_len_q  <= best_len_d;
            best_ofs_q  <= best_ofs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            match_len_q <= match_len_d;
            match_ofs_q <= match_ofs_d;
            next_sym_q  <= next_sym_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match_len = match_len_q;
    assign bus.match_ofs = match_ofs_q;
    assign bus.next_sym  = next_sym_q;

endmodule
